// File: rtl/cpc_bus_pkg.sv
// Shared CPC expansion-bus definitions: capture FSM states and I/O port decode constants.
package cpc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUAL    = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // Gate-array writes carry a function tag in data[7:6]; 2'b10 selects the mode register.
    localparam logic [1:0] GA_MODE_TAG = 2'b10;
    localparam int         LROM_BIT    = 2;
    localparam int         UROM_BIT    = 3;

endpackage

// File: rtl/cpc_strobe_sync.sv
// Multi-flop synchroniser for active-low bus strobes; flops reset to the deasserted level.
module cpc_strobe_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 2
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic [WIDTH-1:0] d_b,
    output logic [WIDTH-1:0] q_b
);

    logic [STAGES-1:0][WIDTH-1:0] sync_pipe;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)
            sync_pipe <= '1;
        else
            sync_pipe <= {sync_pipe[STAGES-2:0], d_b};
    end

    assign q_b = sync_pipe[STAGES-1];

endmodule

// File: rtl/cpc_iowr_capture.sv
// Captures ROM select (&DFxx) and gate-array ROM enable bits (&7Fxx) from qualified Z80 I/O writes.
module cpc_iowr_capture
    import cpc_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int QUAL_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       adr15,
    input  logic       adr14,
    input  logic       adr13,
    input  logic       ioreq_b,
    input  logic       wr_b,
    input  logic [7:0] data,
    output logic [7:0] romsel_q,
    output logic       romsel_upd,
    output logic       lrom_dis,
    output logic       urom_dis,
    output logic [7:0] wr_count
);

    // Capture must land inside the 3-T-state OUT strobe window.
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("cpc_iowr_capture: SYNC_STAGES must be at least 2");
    end
    if (QUAL_CYCLES < 1 || QUAL_CYCLES > 7) begin : g_chk_qual
        $error("cpc_iowr_capture: QUAL_CYCLES must be in 1..7");
    end
    if (SYNC_STAGES + QUAL_CYCLES + 1 > 6) begin : g_chk_lat
        $error("cpc_iowr_capture: SYNC_STAGES+QUAL_CYCLES+1 exceeds the OUT strobe window");
    end

    logic [1:0] strb_s_b;
    logic       io_wr_s;
    logic [2:0] adr_cls;
    logic [2:0] cls_q;
    logic [3:0] qcnt;
    logic       sel_hit;
    logic       ga_hit;
    state_t     state;

    cpc_strobe_sync #(
        .STAGES(SYNC_STAGES),
        .WIDTH (2)
    ) u_sync (
        .clk    (clk),
        .reset_b(reset_b),
        .d_b    ({ioreq_b, wr_b}),
        .q_b    (strb_s_b)
    );

    assign io_wr_s = ~strb_s_b[1] & ~strb_s_b[0];
    assign adr_cls = {adr15, adr14, adr13};

    // Decode uses the class latched when the strobe first qualified.
    assign sel_hit = ~cls_q[0];
    assign ga_hit  = ~cls_q[2] & cls_q[1] & (data[7:6] == GA_MODE_TAG);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state      <= IDLE;
            cls_q      <= '0;
            qcnt       <= '0;
            romsel_q   <= '0;
            romsel_upd <= 1'b0;
            lrom_dis   <= 1'b0;
            urom_dis   <= 1'b0;
            wr_count   <= '0;
        end else begin
            romsel_upd <= 1'b0;
            case (state)
                IDLE: begin
                    if (io_wr_s) begin
                        cls_q <= adr_cls;
                        qcnt  <= 4'd1;
                        state <= (QUAL_CYCLES == 1) ? CAPTURE : QUAL;
                    end
                end
                QUAL: begin
                    if (!io_wr_s || adr_cls != cls_q)
                        state <= IDLE;
                    else begin
                        qcnt <= qcnt + 4'd1;
                        if (qcnt + 4'd1 >= 4'(QUAL_CYCLES))
                            state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (sel_hit) begin
                        romsel_q   <= data;
                        romsel_upd <= 1'b1;
                    end
                    if (ga_hit) begin
                        lrom_dis <= data[LROM_BIT];
                        urom_dis <= data[UROM_BIT];
                    end
                    if (sel_hit || ga_hit)
                        wr_count <= wr_count + 8'd1;
                    state <= HOLD;
                end
                HOLD: begin
                    // One capture per bus cycle: wait for the strobe to release.
                    if (!io_wr_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpc_iowr_capture.sv
// Directed bench for cpc_iowr_capture with a behavioural scoreboard of expected register state.
module tb_cpc_iowr_capture;
    import cpc_bus_pkg::*;

    localparam int QC = 2;

    logic       clk = 1'b0;
    logic       reset_b = 1'b0;
    logic       adr15 = 1'b1, adr14 = 1'b1, adr13 = 1'b1;
    logic       ioreq_b = 1'b1, wr_b = 1'b1;
    logic [7:0] data = 8'h00;
    logic [7:0] romsel_q;
    logic       romsel_upd;
    logic       lrom_dis;
    logic       urom_dis;
    logic [7:0] wr_count;

    cpc_iowr_capture #(.SYNC_STAGES(2), .QUAL_CYCLES(QC)) dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .adr15     (adr15),
        .adr14     (adr14),
        .adr13     (adr13),
        .ioreq_b   (ioreq_b),
        .wr_b      (wr_b),
        .data      (data),
        .romsel_q  (romsel_q),
        .romsel_upd(romsel_upd),
        .lrom_dis  (lrom_dis),
        .urom_dis  (urom_dis),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int pulses = 0;
    int last_cyc = 0;
    int t_start = 0;
    int n_checks = 0;
    int n_err = 0;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (romsel_upd === 1'b1) begin pulses++; last_cyc = cyc; end

    typedef struct {
        logic [7:0] romsel;
        logic       lrom;
        logic       urom;
        logic [7:0] cnt;
        int         pulses;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_romsel = 0, m_cnt = 0;
    logic       m_lrom = 0, m_urom = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_romsel"}, 32'(romsel_q), 0);
        chk({tag, "_upd"},    32'(romsel_upd), 0);
        chk({tag, "_lrom"},   32'(lrom_dis), 0);
        chk({tag, "_urom"},   32'(urom_dis), 0);
        chk({tag, "_cnt"},    32'(wr_count), 0);
        chk({tag, "_state"},  32'(dut.state), 32'(IDLE));
    endtask

    task automatic clear_model();
        m_romsel = 0; m_cnt = 0; m_lrom = 0; m_urom = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_b = 1'b0;
        #1;
        chk_zero("reset");
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
    endtask

    // One Z80 I/O cycle: strobes low for len clocks, address/data held well past capture.
    task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input int len,
                             input bit is_wr, input string tag);
        exp_t e;
        int   p0;
        bit   acc, sel, ga;
        acc = is_wr && (len >= QC);
        sel = !a[13];
        ga  = !a[15] && a[14] && (d[7:6] == 2'b10);
        e.pulses = 0;
        if (acc && sel) begin m_romsel = d; e.pulses = 1; end
        if (acc && ga) begin m_lrom = d[2]; m_urom = d[3]; end
        if (acc && (sel || ga)) m_cnt = m_cnt + 8'd1;
        e.romsel = m_romsel; e.lrom = m_lrom; e.urom = m_urom; e.cnt = m_cnt;
        sb.push_back(e);

        @(negedge clk); #1;
        p0 = pulses;
        {adr15, adr14, adr13} = a[15:13];
        data    = d;
        ioreq_b = 1'b0;
        wr_b    = !is_wr;
        t_start = cyc;
        repeat (len) @(negedge clk);
        ioreq_b = 1'b1;
        wr_b    = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, "_romsel"}, 32'(romsel_q), 32'(e.romsel));
        chk({tag, "_lrom"},   32'(lrom_dis), 32'(e.lrom));
        chk({tag, "_urom"},   32'(urom_dis), 32'(e.urom));
        chk({tag, "_cnt"},    32'(wr_count), 32'(e.cnt));
        chk({tag, "_pulses"}, 32'(pulses - p0), 32'(e.pulses));
    endtask

    // Start a write, assert reset once the FSM reaches exp_state, check everything clears.
    task automatic reset_mid(input int n, input state_t exp_state, input string tag);
        int p0;
        @(negedge clk); #1;
        {adr15, adr14, adr13} = 3'b110;
        data    = 8'h3C;
        ioreq_b = 1'b0;
        wr_b    = 1'b0;
        repeat (n) @(negedge clk); #1;
        chk({tag, "_pre_state"}, 32'(dut.state), 32'(exp_state));
        reset_b = 1'b0;
        #1;
        chk_zero(tag);
        p0 = pulses;
        repeat (2) @(negedge clk);
        ioreq_b = 1'b1;
        wr_b    = 1'b1;
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        clear_model();
        repeat (6) @(negedge clk); #1;
        chk({tag, "_no_pulse"}, 32'(pulses - p0), 0);
        chk({tag, "_post_cnt"}, 32'(wr_count), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();

        bus_cycle(16'hDF00, 8'h07, 3, 1'b1, "sel07");
        chk("sel07_latency", 32'(last_cyc - t_start), 32'd5);

        bus_cycle(16'h7F00, 8'h8C, 3, 1'b1, "ga8C");
        bus_cycle(16'h7F00, 8'h80, 3, 1'b1, "ga80");
        bus_cycle(16'h7F00, 8'h4C, 3, 1'b1, "ga_badtag");

        bus_cycle(16'h5F00, 8'h89, 3, 1'b1, "both89");

        bus_cycle(16'hDF00, 8'h55, 1, 1'b1, "glitch");
        chk("glitch_state", 32'(dut.state), 32'(IDLE));
        bus_cycle(16'hDF00, 8'hA5, 10, 1'b1, "held10");

        reset_mid(3, QUAL, "rst_qual");
        bus_cycle(16'hDF00, 8'h03, 3, 1'b1, "after_qual");
        reset_mid(8, HOLD, "rst_hold");
        bus_cycle(16'hDF00, 8'h03, 3, 1'b1, "after_hold");

        bus_cycle(16'hDF00, 8'hEE, 3, 1'b0, "read");

        do_reset();
        for (int i = 0; i < 256; i++)
            bus_cycle(16'hDF00, 8'(i), 3, 1'b1, "wrap");
        chk("wrap_final", 32'(wr_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
